serial_subtractor_ctrl: RTL

//   Bit-serial N-bit unsigned subtractor controller. Sequences one 1-bit

---
 rtl/serial_sub_pkg.sv | 7 +
 rtl/half_subtractor.sv | 10 +
 rtl/serial_sub_bit.sv | 13 +
 rtl/serial_subtractor_ctrl.sv | 64 ++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encodings and default width for the serial subtractor
package serial_sub_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/half_subtractor.sv
// half_subtractor: one-bit difference and borrow of x - y
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic b
);
  assign d = x ^ y;
  assign b = ~x & y;
endmodule

// File: rtl/serial_sub_bit.sv
// serial_sub_bit: full-subtract cell built from two half subtractors and an OR
module serial_sub_bit (
  input  logic ai,
  input  logic bi,
  input  logic br,
  output logic d,
  output logic br_next
);
  logic d1, b1, b2;
  half_subtractor hs_ab (.x(ai), .y(bi), .d(d1), .b(b1));
  half_subtractor hs_br (.x(d1), .y(br), .d(d),  .b(b2));
  assign br_next = b1 | b2;
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: LSB-first bit-serial unsigned subtractor with start/busy/done handshake
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, borrow_q, borrow_d;
  logic             d, br_next, run, accept, last;
  serial_sub_bit u_bit (.ai(a_q[0]), .bi(b_q[0]), .br(br_q), .d(d), .br_next(br_next));
  // next-state, shift and capture logic; the counter holds on the final bit so it never wraps
  always_comb begin
    run      = state_q == S_RUN;
    accept   = start && (state_q == S_IDLE || state_q == S_DONE);
    last     = run && cnt_q == CW'(WIDTH - 1);
    state_d  = accept ? S_RUN : run ? (last ? S_DONE : S_RUN) : S_IDLE;
    a_d      = accept ? a : run ? a_q >> 1 : a_q;
    b_d      = accept ? b : run ? b_q >> 1 : b_q;
    br_d     = accept ? 1'b0 : run ? br_next : br_q;
    cnt_d    = accept ? '0 : (run && !last) ? cnt_q + 1'b1 : cnt_q;
    res_d    = accept ? '0 : run ? {d, res_q[WIDTH-1:1]} : res_q;
    diff_d   = last ? res_d : diff_q;
    borrow_d = last ? br_next : borrow_q;
  end
  // state and datapath registers, cleared asynchronously so a reset aborts any operation at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
    end
  end
  assign busy       = state_q == S_RUN;
  assign done       = state_q == S_DONE;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
endmodule
